vedic_4b_mul: RTL and testbench

- Unsigned 4x4-bit multiplier built on the Vedic (Urdhva Tiryagbhyam) vertical-and-crosswise structure.
- The main product is purely combinational and available in the same evaluation as the inputs.
- A registered copy of the product is also provided for pipelined consumers in the datapath.
- Used as a leaf arithmetic block inside the in-order single-issue processor's multiply path.

---
 rtl/vedic_4b_mul.sv | 65 ++++++
 tb/tb_vedic_4b_mul.sv | 129 ++++++++++++
 2 files changed

// File: rtl/vedic_4b_mul.sv
// vedic_4b_mul: unsigned 4x4 Urdhva Tiryagbhyam multiplier with a registered product copy.
`timescale 1ns/1ps
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;
  always_comb begin
    p[0] = a[0] & b[0];
    p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    c1   = (a[1] & b[0]) & (a[0] & b[1]);
    p[2] = (a[1] & b[1]) ^ c1;
    p[3] = (a[1] & b[1]) & c1;
  end
endmodule

// Ripple-carry adder; the carry out of the top bit is discarded by design.
module vedic_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s
);
  logic [W-1:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i] = x[i] ^ y[i] ^ c[i];
    if (i < W - 1) begin : g_c
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end
endmodule

module vedic_4b_mul (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [8:0] prod,
  output logic [8:0] prod_q,
  output logic       prod_vld
);
  logic [3:0] q0, q1, q2, q3;
  logic [4:0] s1, s2;
  logic [5:0] s3;
  vedic_2x2 u_m0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_2x2 u_m1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_2x2 u_m2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_2x2 u_m3 (.a(a[3:2]), .b(b[3:2]), .p(q3));
  vedic_rca #(.W(5)) u_s1 (.x({1'b0, q1}), .y({1'b0, q2}), .s(s1));
  vedic_rca #(.W(5)) u_s2 (.x(s1), .y({3'b000, q0[3:2]}), .s(s2));
  vedic_rca #(.W(6)) u_s3 (.x({q3, 2'b00}), .y({1'b0, s2}), .s(s3));
  assign prod = {1'b0, s3, q0[1:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_q   <= prod;
      prod_vld <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vedic_4b_mul.sv
// tb_vedic_4b_mul: self-checking bench comparing the multiplier against plain integer products.
`timescale 1ns/1ps
module tb_vedic_4b_mul;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic [8:0] prod, prod_q;
  logic       prod_vld;
  int checks = 0;
  int errors = 0;

  vedic_4b_mul dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .prod(prod), .prod_q(prod_q), .prod_vld(prod_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model(input int x, input int y);
    return 9'(x * y);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; a = 4'd7; b = 4'd6;
    repeat (3) @(negedge clk);
    checks++;
    if (prod !== 9'd42) begin errors++; $display("FAIL reset_prod: got %0d want 42", prod); end
    checks++;
    if (prod_q !== 9'd0) begin errors++; $display("FAIL reset_prod_q: got %0d want 0", prod_q); end
    checks++;
    if (prod_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", prod_vld); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (prod_q !== 9'd42) begin errors++; $display("FAIL release_prod_q: got %0d want 42", prod_q); end
    checks++;
    if (prod_vld !== 1'b1) begin errors++; $display("FAIL release_vld: got %b want 1", prod_vld); end
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        a = 4'(i); b = 4'(j); #1;
        checks++;
        if (prod !== model(i, j) || prod[8] !== 1'b0) begin
          errors++; $display("FAIL sweep %0d*%0d: got %0d want %0d", i, j, prod, model(i, j));
        end
      end
  endtask

  task automatic test_corners();
    int tab [4][2] = '{'{15, 15}, '{0, 13}, '{1, 9}, '{8, 8}};
    int want [4] = '{225, 0, 9, 64};
    for (int k = 0; k < 4; k++) begin
      a = 4'(tab[k][0]); b = 4'(tab[k][1]); #1;
      checks++;
      if (prod !== 9'(want[k])) begin
        errors++; $display("FAIL corner %0d*%0d: got %0d want %0d", tab[k][0], tab[k][1], prod, want[k]);
      end
    end
  endtask

  task automatic test_random();
    int x, y;
    for (int k = 0; k < 100; k++) begin
      x = $urandom_range(0, 15); y = $urandom_range(0, 15);
      a = 4'(x); b = 4'(y); #1;
      checks++;
      if (prod !== model(x, y)) begin
        errors++; $display("FAIL random %0d*%0d: got %0d want %0d", x, y, prod, model(x, y));
      end
      #4;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 4'd15; b = 4'd15;
    @(posedge clk); #1;
    checks++;
    if (prod_q !== 9'd225) begin errors++; $display("FAIL async_pre_prod_q: got %0d want 225", prod_q); end
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    checks++;
    if (prod_q !== 9'd0) begin errors++; $display("FAIL async_prod_q: got %0d want 0", prod_q); end
    checks++;
    if (prod_vld !== 1'b0) begin errors++; $display("FAIL async_vld: got %b want 0", prod_vld); end
    checks++;
    if (prod !== 9'd225) begin errors++; $display("FAIL async_prod: got %0d want 225", prod); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (prod_q !== 9'd225 || prod_vld !== 1'b1) begin
      errors++; $display("FAIL async_recover: got %0d/%b want 225/1", prod_q, prod_vld);
    end
  endtask

  task automatic test_tracking();
    int tab [3][2] = '{'{3, 5}, '{12, 11}, '{9, 2}};
    logic [8:0] prev = 9'd225;
    logic [8:0] exp_p;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 4'(tab[k][0]); b = 4'(tab[k][1]); #1;
      exp_p = model(tab[k][0], tab[k][1]);
      checks++;
      if (prod !== exp_p || prod_q !== prev) begin
        errors++; $display("FAIL track_before %0d: got %0d/%0d want %0d/%0d", k, prod, prod_q, exp_p, prev);
      end
      @(posedge clk); #1;
      checks++;
      if (prod_q !== exp_p) begin
        errors++; $display("FAIL track_after %0d: got %0d want %0d", k, prod_q, exp_p);
      end
      prev = exp_p;
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_corners();
    test_random();
    test_async_reset();
    test_tracking();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
